// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS main controller: registered opcode class, FETCH/DECODE/EXEC/MEM/WB sequencing.
// Strobes are combinational from state/class; FETCH and MEM stall on mem_ready with an optional bus timeout.
module mips_multicycle_controller #(
  parameter bit ENABLE_BYTE = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  input  logic       i_neg,
  output logic [2:0] o_state,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_byte,
  output logic       o_reg_write,
  output logic       o_reg_dst_rt,
  output logic       o_mem_to_reg,
  output logic       o_link,
  output logic       o_alu_src_imm,
  output logic       o_imm_zext,
  output logic       o_lui_sel,
  output logic [3:0] o_alu_op,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic       o_bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_ALUI, C_BR, C_LD, C_ST, C_J, C_ILL
  } cls_t;

  localparam logic [TW-1:0] TO_LIM = TW'(MEM_TIMEOUT);
  localparam bit            TO_EN  = (MEM_TIMEOUT != 0);

  state_t        r_state, w_state_nxt;
  cls_t          r_cls, w_dec_cls;
  logic [5:0]    r_op;
  logic [TW-1:0] r_cnt, w_cnt_nxt;

  logic       w_ir_write, w_pc_write, w_mem_read, w_mem_write, w_mem_byte;
  logic       w_reg_write, w_reg_dst_rt, w_mem_to_reg, w_link;
  logic       w_alu_src_imm, w_imm_zext, w_lui_sel;
  logic       w_instr_done, w_illegal, w_bus_error, w_timeout, w_br_taken;
  logic [1:0] w_pc_src;
  logic [3:0] w_alu_op, w_imm_alu_op;
  logic       w_imm_zext_dec, w_imm_lui_dec;

  always_comb begin
    w_dec_cls = C_ILL;
    case (i_opcode)
      6'b000000: w_dec_cls = C_R;
      6'b001000, 6'b001001, 6'b001010, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: w_dec_cls = C_ALUI;
      6'b000001, 6'b000100, 6'b000101,
      6'b000110, 6'b000111: w_dec_cls = C_BR;
      6'b100011: w_dec_cls = C_LD;
      6'b101011: w_dec_cls = C_ST;
      6'b100000: if (ENABLE_BYTE) w_dec_cls = C_LD;
      6'b101000: if (ENABLE_BYTE) w_dec_cls = C_ST;
      6'b000010, 6'b000011: w_dec_cls = C_J;
      default: w_dec_cls = C_ILL;
    endcase
  end

  // Sub-operation decode runs off the latched opcode, valid from EXEC onward.
  always_comb begin
    w_imm_alu_op   = 4'd0;
    w_imm_zext_dec = 1'b0;
    w_imm_lui_dec  = 1'b0;
    case (r_op)
      6'b001001: w_imm_alu_op = 4'd1;
      6'b001010: w_imm_alu_op = 4'd6;
      6'b001100: begin w_imm_alu_op = 4'd3; w_imm_zext_dec = 1'b1; end
      6'b001101: begin w_imm_alu_op = 4'd4; w_imm_zext_dec = 1'b1; end
      6'b001110: begin w_imm_alu_op = 4'd5; w_imm_zext_dec = 1'b1; end
      6'b001111: begin w_imm_alu_op = 4'd4; w_imm_lui_dec  = 1'b1; end
      default:   w_imm_alu_op = 4'd0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (r_op)
      6'b000100: w_br_taken = i_zero;
      6'b000101: w_br_taken = !i_zero;
      6'b000110: w_br_taken = i_neg | i_zero;
      6'b000111: w_br_taken = !i_neg & !i_zero;
      6'b000001: w_br_taken = !i_neg;
      default:   w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 2'd0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_byte    = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst_rt  = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_link        = 1'b0;
    w_alu_src_imm = 1'b0;
    w_imm_zext    = 1'b0;
    w_lui_sel     = 1'b0;
    w_alu_op      = 4'd0;
    w_instr_done  = 1'b0;
    w_illegal     = 1'b0;
    w_bus_error   = 1'b0;
    // A ready arriving on the limit cycle takes priority over the timeout.
    w_timeout     = TO_EN && (r_cnt == TO_LIM) && !i_mem_ready;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (i_mem_ready) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        case (w_dec_cls)
          C_J: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'd2;
            w_instr_done = 1'b1;
            w_reg_write  = i_opcode[0];
            w_link       = i_opcode[0];
            w_state_nxt  = S_FETCH;
          end
          C_ILL: begin
            w_illegal   = 1'b1;
            w_state_nxt = S_FETCH;
          end
          default: w_state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          C_R: begin
            w_alu_op    = 4'd7;
            w_state_nxt = S_WB;
          end
          C_ALUI: begin
            w_alu_src_imm = 1'b1;
            w_alu_op      = w_imm_alu_op;
            w_imm_zext    = w_imm_zext_dec;
            w_lui_sel     = w_imm_lui_dec;
            w_state_nxt   = S_WB;
          end
          C_LD, C_ST: begin
            w_alu_op      = 4'd1;
            w_alu_src_imm = 1'b1;
            w_state_nxt   = S_MEM;
          end
          C_BR: begin
            w_alu_op     = 4'd2;
            w_pc_write   = w_br_taken;
            w_pc_src     = w_br_taken ? 2'd1 : 2'd0;
            w_instr_done = 1'b1;
            w_state_nxt  = S_FETCH;
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_mem_read  = (r_cls == C_LD);
        w_mem_write = (r_cls == C_ST);
        w_mem_byte  = (r_op == 6'b100000) || (r_op == 6'b101000);
        if (i_mem_ready) begin
          if (r_cls == C_LD) begin
            w_state_nxt = S_WB;
          end else begin
            w_instr_done = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        end else if (w_timeout) begin
          w_bus_error = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst_rt = (r_cls == C_ALUI) || (r_cls == C_LD);
        w_mem_to_reg = (r_cls == C_LD);
        w_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase

    w_cnt_nxt = r_cnt;
    if ((w_state_nxt != r_state) || w_bus_error) begin
      w_cnt_nxt = '0;
    end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready) begin
      w_cnt_nxt = r_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_cls   <= C_NONE;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
        r_op  <= i_opcode;
      end
    end
  end

  assign o_state       = i_rst ? 3'd0 : r_state;
  assign o_ir_write    = w_ir_write & ~i_rst;
  assign o_pc_write    = w_pc_write & ~i_rst;
  assign o_pc_src      = w_pc_src & {2{~i_rst}};
  assign o_mem_read    = w_mem_read & ~i_rst;
  assign o_mem_write   = w_mem_write & ~i_rst;
  assign o_mem_byte    = w_mem_byte & ~i_rst;
  assign o_reg_write   = w_reg_write & ~i_rst;
  assign o_reg_dst_rt  = w_reg_dst_rt & ~i_rst;
  assign o_mem_to_reg  = w_mem_to_reg & ~i_rst;
  assign o_link        = w_link & ~i_rst;
  assign o_alu_src_imm = w_alu_src_imm & ~i_rst;
  assign o_imm_zext    = w_imm_zext & ~i_rst;
  assign o_lui_sel     = w_lui_sel & ~i_rst;
  assign o_alu_op      = w_alu_op & {4{~i_rst}};
  assign o_instr_done  = w_instr_done & ~i_rst;
  assign o_illegal     = w_illegal & ~i_rst;
  assign o_bus_error   = w_bus_error & ~i_rst;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-cycle expected strobe vectors queued by the stimulus, popped by a monitor.
// dut_a: byte ops enabled, 4-cycle bus timeout; dut_b: byte ops disabled, timeout off.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       reg_write;
    logic       reg_dst_rt;
    logic       mem_to_reg;
    logic       link;
    logic       alu_src_imm;
    logic       imm_zext;
    logic       lui_sel;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_error;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  bit         sel = 1'b0;

  int checks = 0;
  int failures = 0;

  out_t  q_exp[$];
  bit    q_sel[$];
  string q_nm[$];

  logic [2:0] a_state, b_state;
  logic [1:0] a_pc_src, b_pc_src;
  logic [3:0] a_alu_op, b_alu_op;
  logic a_ir_write, a_pc_write, a_mem_read, a_mem_write, a_mem_byte, a_reg_write, a_reg_dst_rt;
  logic a_mem_to_reg, a_link, a_alu_src_imm, a_imm_zext, a_lui_sel, a_instr_done, a_illegal, a_bus_error;
  logic b_ir_write, b_pc_write, b_mem_read, b_mem_write, b_mem_byte, b_reg_write, b_reg_dst_rt;
  logic b_mem_to_reg, b_link, b_alu_src_imm, b_imm_zext, b_lui_sel, b_instr_done, b_illegal, b_bus_error;
  out_t out_a, out_b;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.ENABLE_BYTE(1'b1), .MEM_TIMEOUT(4), .TW(3)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_opcode(opcode), .i_mem_ready(mem_ready),
    .i_zero(zero), .i_neg(neg), .o_state(a_state), .o_ir_write(a_ir_write),
    .o_pc_write(a_pc_write), .o_pc_src(a_pc_src), .o_mem_read(a_mem_read),
    .o_mem_write(a_mem_write), .o_mem_byte(a_mem_byte), .o_reg_write(a_reg_write),
    .o_reg_dst_rt(a_reg_dst_rt), .o_mem_to_reg(a_mem_to_reg), .o_link(a_link),
    .o_alu_src_imm(a_alu_src_imm), .o_imm_zext(a_imm_zext), .o_lui_sel(a_lui_sel),
    .o_alu_op(a_alu_op), .o_instr_done(a_instr_done), .o_illegal(a_illegal),
    .o_bus_error(a_bus_error)
  );

  mips_multicycle_controller #(.ENABLE_BYTE(1'b0), .MEM_TIMEOUT(0), .TW(5)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_opcode(opcode), .i_mem_ready(mem_ready),
    .i_zero(zero), .i_neg(neg), .o_state(b_state), .o_ir_write(b_ir_write),
    .o_pc_write(b_pc_write), .o_pc_src(b_pc_src), .o_mem_read(b_mem_read),
    .o_mem_write(b_mem_write), .o_mem_byte(b_mem_byte), .o_reg_write(b_reg_write),
    .o_reg_dst_rt(b_reg_dst_rt), .o_mem_to_reg(b_mem_to_reg), .o_link(b_link),
    .o_alu_src_imm(b_alu_src_imm), .o_imm_zext(b_imm_zext), .o_lui_sel(b_lui_sel),
    .o_alu_op(b_alu_op), .o_instr_done(b_instr_done), .o_illegal(b_illegal),
    .o_bus_error(b_bus_error)
  );

  assign out_a = {a_state, a_ir_write, a_pc_write, a_pc_src, a_mem_read, a_mem_write, a_mem_byte,
                  a_reg_write, a_reg_dst_rt, a_mem_to_reg, a_link, a_alu_src_imm, a_imm_zext,
                  a_lui_sel, a_alu_op, a_instr_done, a_illegal, a_bus_error};
  assign out_b = {b_state, b_ir_write, b_pc_write, b_pc_src, b_mem_read, b_mem_write, b_mem_byte,
                  b_reg_write, b_reg_dst_rt, b_mem_to_reg, b_link, b_alu_src_imm, b_imm_zext,
                  b_lui_sel, b_alu_op, b_instr_done, b_illegal, b_bus_error};

  // Monitor: outputs are checked at the falling edge, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q_exp.size() != 0) begin
        out_t  e;
        out_t  a;
        bit    s;
        string n;
        e = q_exp.pop_front();
        s = q_sel.pop_front();
        n = q_nm.pop_front();
        a = s ? out_b : out_a;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: dut_%s got %h required %h", n, s ? "b" : "a", a, e);
        end
      end
    end
  end

  function automatic out_t mk(input logic [2:0] st);
    out_t r;
    r = '0;
    r.state = st;
    return r;
  endfunction

  function automatic out_t f_wait();
    out_t r;
    r = mk(3'd0);
    r.mem_read = 1'b1;
    return r;
  endfunction

  function automatic out_t f_hit();
    out_t r;
    r = f_wait();
    r.ir_write = 1'b1;
    r.pc_write = 1'b1;
    return r;
  endfunction

  task automatic cyc(input string nm, input logic [5:0] op, input logic rdy,
                     input logic z, input logic n, input out_t e);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    neg       = n;
    q_exp.push_back(e);
    q_sel.push_back(sel);
    q_nm.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_instr(input string nm, input logic [5:0] op, input logic [3:0] aop,
                           input logic imm, input logic zext, input logic lui);
    out_t e;
    cyc({nm, "_fetch"}, op, 1'b1, 1'b0, 1'b0, f_hit());
    cyc({nm, "_decode"}, op, 1'b0, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2);
    e.alu_op = aop; e.alu_src_imm = imm; e.imm_zext = zext; e.lui_sel = lui;
    cyc({nm, "_exec"}, op, 1'b0, 1'b0, 1'b0, e);
    e = mk(3'd4);
    e.reg_write = 1'b1; e.reg_dst_rt = imm; e.instr_done = 1'b1;
    cyc({nm, "_wb"}, op, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic branch(input string nm, input logic [5:0] op, input logic z, input logic n,
                        input logic taken);
    out_t e;
    cyc({nm, "_fetch"}, op, 1'b1, 1'b0, 1'b0, f_hit());
    cyc({nm, "_decode"}, op, 1'b0, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2);
    e.alu_op = 4'd2; e.instr_done = 1'b1;
    e.pc_write = taken; e.pc_src = taken ? 2'd1 : 2'd0;
    cyc({nm, "_exec"}, op, 1'b0, z, n, e);
  endtask

  task automatic mem_instr(input string nm, input logic [5:0] op, input logic load,
                           input logic byt, input int waits);
    out_t e;
    cyc({nm, "_fetch"}, op, 1'b1, 1'b0, 1'b0, f_hit());
    cyc({nm, "_decode"}, op, 1'b0, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2);
    e.alu_op = 4'd1; e.alu_src_imm = 1'b1;
    cyc({nm, "_exec"}, op, 1'b0, 1'b0, 1'b0, e);
    e = mk(3'd3);
    e.mem_read = load; e.mem_write = !load; e.mem_byte = byt;
    for (int i = 0; i < waits; i++) cyc({nm, "_mem_wait"}, op, 1'b0, 1'b0, 1'b0, e);
    e.instr_done = !load;
    cyc({nm, "_mem_done"}, op, 1'b1, 1'b0, 1'b0, e);
    if (load) begin
      e = mk(3'd4);
      e.reg_write = 1'b1; e.reg_dst_rt = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
      cyc({nm, "_wb"}, op, 1'b0, 1'b0, 1'b0, e);
    end
  endtask

  initial begin
    out_t e;
    @(posedge clk);
    #1;
    repeat (2) cyc("reset_idle", 6'b001000, 1'b1, 1'b0, 1'b0, mk(3'd0));
    rst_a = 1'b0;

    alu_instr("addi",  6'b001000, 4'd0, 1'b1, 1'b0, 1'b0);
    alu_instr("addiu", 6'b001001, 4'd1, 1'b1, 1'b0, 1'b0);
    alu_instr("andi",  6'b001100, 4'd3, 1'b1, 1'b1, 1'b0);
    alu_instr("ori",   6'b001101, 4'd4, 1'b1, 1'b1, 1'b0);
    alu_instr("xori",  6'b001110, 4'd5, 1'b1, 1'b1, 1'b0);
    alu_instr("lui",   6'b001111, 4'd4, 1'b1, 1'b0, 1'b1);
    alu_instr("slti",  6'b001010, 4'd6, 1'b1, 1'b0, 1'b0);
    alu_instr("rtype", 6'b000000, 4'd7, 1'b0, 1'b0, 1'b0);

    branch("beq_t",   6'b000100, 1'b1, 1'b0, 1'b1);
    branch("beq_nt",  6'b000100, 1'b0, 1'b0, 1'b0);
    branch("bne_t",   6'b000101, 1'b0, 1'b0, 1'b1);
    branch("bne_nt",  6'b000101, 1'b1, 1'b0, 1'b0);
    branch("blez_t",  6'b000110, 1'b0, 1'b1, 1'b1);
    branch("blez_nt", 6'b000110, 1'b0, 1'b0, 1'b0);
    branch("bgtz_t",  6'b000111, 1'b0, 1'b0, 1'b1);
    branch("bgtz_nt", 6'b000111, 1'b1, 1'b0, 1'b0);
    branch("bgez_t",  6'b000001, 1'b1, 1'b0, 1'b1);
    branch("bgez_nt", 6'b000001, 1'b0, 1'b1, 1'b0);

    mem_instr("lw_wait3", 6'b100011, 1'b1, 1'b0, 3);
    mem_instr("lb",       6'b100000, 1'b1, 1'b1, 0);
    mem_instr("sw",       6'b101011, 1'b0, 1'b0, 0);
    mem_instr("sb",       6'b101000, 1'b0, 1'b1, 1);

    // Store whose bus never answers: error on the 5th MEM cycle, no instr_done.
    cyc("swto_fetch", 6'b101011, 1'b1, 1'b0, 1'b0, f_hit());
    cyc("swto_decode", 6'b101011, 1'b0, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.alu_op = 4'd1; e.alu_src_imm = 1'b1;
    cyc("swto_exec", 6'b101011, 1'b0, 1'b0, 1'b0, e);
    e = mk(3'd3); e.mem_write = 1'b1;
    repeat (4) cyc("swto_mem_wait", 6'b101011, 1'b0, 1'b0, 1'b0, e);
    e.bus_error = 1'b1;
    cyc("swto_bus_error", 6'b101011, 1'b0, 1'b0, 1'b0, e);

    repeat (4) cyc("fetch_wait", 6'b000011, 1'b0, 1'b0, 1'b0, f_wait());
    e = f_wait(); e.bus_error = 1'b1;
    cyc("fetch_bus_error", 6'b000011, 1'b0, 1'b0, 1'b0, e);
    repeat (4) cyc("fetch_wait2", 6'b000011, 1'b0, 1'b0, 1'b0, f_wait());
    cyc("fetch_ready_at_limit", 6'b000011, 1'b1, 1'b0, 1'b0, f_hit());

    e = mk(3'd1); e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1; e.link = 1'b1;
    e.instr_done = 1'b1;
    cyc("jal_decode", 6'b000011, 1'b0, 1'b0, 1'b0, e);
    cyc("j_fetch", 6'b000010, 1'b1, 1'b0, 1'b0, f_hit());
    e = mk(3'd1); e.pc_write = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
    cyc("j_decode", 6'b000010, 1'b0, 1'b0, 1'b0, e);

    cyc("ill_fetch", 6'b111111, 1'b1, 1'b0, 1'b0, f_hit());
    e = mk(3'd1); e.illegal = 1'b1;
    cyc("ill_decode", 6'b111111, 1'b0, 1'b0, 1'b0, e);

    cyc("rst_fetch", 6'b001000, 1'b1, 1'b0, 1'b0, f_hit());
    cyc("rst_decode", 6'b001000, 1'b1, 1'b0, 1'b0, mk(3'd1));
    rst_a = 1'b1;
    cyc("rst_in_exec", 6'b001000, 1'b1, 1'b0, 1'b0, mk(3'd0));
    rst_a = 1'b0;
    cyc("post_rst_fetch", 6'b001000, 1'b0, 1'b0, 1'b0, f_wait());
    alu_instr("addi_after_rst", 6'b001000, 4'd0, 1'b1, 1'b0, 1'b0);

    sel   = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b0;
    e = mk(3'd1); e.illegal = 1'b1;
    cyc("b_sb_fetch", 6'b101000, 1'b1, 1'b0, 1'b0, f_hit());
    cyc("b_sb_illegal", 6'b101000, 1'b1, 1'b0, 1'b0, e);
    cyc("b_op3f_fetch", 6'b111111, 1'b1, 1'b0, 1'b0, f_hit());
    cyc("b_op3f_illegal", 6'b111111, 1'b1, 1'b0, 1'b0, e);
    cyc("b_lb_fetch", 6'b100000, 1'b1, 1'b0, 1'b0, f_hit());
    cyc("b_lb_illegal", 6'b100000, 1'b1, 1'b0, 1'b0, e);
    repeat (20) cyc("b_no_timeout", 6'b100011, 1'b0, 1'b0, 1'b0, f_wait());
    mem_instr("b_lw", 6'b100011, 1'b1, 1'b0, 2);

    repeat (3) @(posedge clk);
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
